// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_arbiter
// Description : Packet-level round-robin arbiter sharing one AXI-Stream
//               master port between NUM_IN stream sources.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arb_en,
    input  logic [NUM_IN-1:0]        s_tvalid,
    input  logic [NUM_IN*DATA_W-1:0] s_tdata,
    input  logic [NUM_IN-1:0]        s_tlast,
    output logic [NUM_IN-1:0]        s_tready,
    output logic                     m_tvalid,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [ID_W-1:0]          m_tid,
    output logic                     busy,
    output logic                     pkt_done
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_rr_ptr_nxt;
    logic [ID_W-1:0]   r_grant_idx;
    logic [ID_W-1:0]   w_grant_nxt;
    logic              r_pkt_done;
    logic              w_last_xfer;
    logic              w_req_any;
    logic [ID_W-1:0]   w_sel_idx;
    logic              w_g_valid;
    logic [DATA_W-1:0] w_g_data;
    logic              w_g_last;

    assign w_req_any = |s_tvalid;
    assign w_g_valid = s_tvalid[r_grant_idx];
    assign w_g_data  = s_tdata[int'(r_grant_idx)*DATA_W +: DATA_W];
    assign w_g_last  = s_tlast[r_grant_idx];
    assign pkt_done  = r_pkt_done;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin : p_select
        int v_idx;
        v_idx     = 0;
        w_sel_idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            v_idx = (int'(r_rr_ptr) + k) % NUM_IN;
            if (s_tvalid[v_idx]) begin
                w_sel_idx = ID_W'(v_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_idx <= w_grant_nxt;
            r_pkt_done  <= w_last_xfer;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_grant_nxt  = r_grant_idx;
        w_last_xfer  = 1'b0;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tlast      = 1'b0;
        m_tid        = '0;
        s_tready     = '0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arb_en && w_req_any) begin
                    w_grant_nxt = w_sel_idx;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                busy                  = 1'b1;
                m_tvalid              = w_g_valid;
                m_tdata               = w_g_data;
                m_tlast               = w_g_last;
                m_tid                 = r_grant_idx;
                s_tready[r_grant_idx] = m_tready;
                // Grant is released only on the tlast handshake; bubbles keep it.
                if (w_g_valid && m_tready && w_g_last) begin
                    w_last_xfer = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (r_grant_idx == ID_W'(NUM_IN - 1)) begin
                        w_rr_ptr_nxt = '0;
                    end else begin
                        w_rr_ptr_nxt = r_grant_idx + ID_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_rr_arbiter
// Description : Directed-vector self-checking bench for axis_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_rr_arbiter;

    localparam int C_NUM_IN = 4;
    localparam int C_DATA_W = 32;
    localparam int C_ID_W   = 2;

    logic                         clk;
    logic                         reset;
    logic                         arb_en;
    logic [C_NUM_IN-1:0]          s_tvalid;
    logic [C_NUM_IN*C_DATA_W-1:0] s_tdata;
    logic [C_NUM_IN-1:0]          s_tlast;
    logic [C_NUM_IN-1:0]          s_tready;
    logic                         m_tvalid;
    logic [C_DATA_W-1:0]          m_tdata;
    logic                         m_tlast;
    logic                         m_tready;
    logic [C_ID_W-1:0]            m_tid;
    logic                         busy;
    logic                         pkt_done;

    int n_vec;
    int n_err;

    axis_rr_arbiter #(
        .NUM_IN (C_NUM_IN),
        .DATA_W (C_DATA_W),
        .ID_W   (C_ID_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .m_tid    (m_tid),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [31:0] d, input logic l);
        s_tvalid[i]                     = v;
        s_tdata[i*C_DATA_W +: C_DATA_W] = d;
        s_tlast[i]                      = l;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"},   32'(busy),     32'd0);
        check_val({tag, "_mvalid"}, 32'(m_tvalid), 32'd0);
        check_val({tag, "_sready"}, 32'(s_tready), 32'd0);
    endtask

    task automatic check_beat(input string tag, input int id, input logic [31:0] d, input logic l);
        check_val({tag, "_busy"},   32'(busy),     32'd1);
        check_val({tag, "_mvalid"}, 32'(m_tvalid), 32'd1);
        check_val({tag, "_tid"},    32'(m_tid),    32'(id));
        check_val({tag, "_tdata"},  m_tdata,       d);
        check_val({tag, "_tlast"},  32'(m_tlast),  32'(l));
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        arb_en   = 1'b0;
        m_tready = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;

        // Reset then idle
        repeat (2) next_cycle();
        @(negedge clk);
        check_idle("rst");
        check_val("rst_tid",   32'(m_tid),    32'd0);
        check_val("rst_pdone", 32'(pkt_done), 32'd0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_idle("idle");
            check_val("idle_tid", 32'(m_tid), 32'd0);
            next_cycle();
        end

        // Single source 2, three beats
        arb_en   = 1'b1;
        m_tready = 1'b1;
        set_src(2, 1'b1, 32'hA0, 1'b0);
        @(negedge clk);
        check_idle("s2_arb");
        next_cycle();
        @(negedge clk);
        check_beat("s2_b0", 2, 32'hA0, 1'b0);
        check_val("s2_b0_sready", 32'(s_tready), 32'b0100);
        next_cycle();
        set_src(2, 1'b1, 32'hA1, 1'b0);
        @(negedge clk);
        check_beat("s2_b1", 2, 32'hA1, 1'b0);
        check_val("s2_b1_pdone", 32'(pkt_done), 32'd0);
        next_cycle();
        set_src(2, 1'b1, 32'hA2, 1'b1);
        @(negedge clk);
        check_beat("s2_b2", 2, 32'hA2, 1'b1);
        check_val("s2_b2_sready", 32'(s_tready), 32'b0100);
        next_cycle();
        set_src(2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check_idle("s2_end");
        check_val("s2_pdone", 32'(pkt_done), 32'd1);
        next_cycle();
        @(negedge clk);
        check_val("s2_pdone_clr", 32'(pkt_done), 32'd0);

        // rr_ptr is now 3: with 0 and 3 requesting, 3 wins (single-beat packets)
        set_src(0, 1'b1, 32'h50, 1'b1);
        set_src(3, 1'b1, 32'h53, 1'b1);
        next_cycle();
        @(negedge clk);
        check_beat("ptr3", 3, 32'h53, 1'b1);
        next_cycle();
        set_src(0, 1'b0, 32'h0, 1'b0);
        set_src(3, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check_idle("ptr3_end");
        check_val("ptr3_pdone", 32'(pkt_done), 32'd1);
        next_cycle();

        // Round-robin rotation, all four offering 2-beat packets
        for (int i = 0; i < C_NUM_IN; i++) set_src(i, 1'b1, 32'h100 * i, 1'b0);
        for (int p = 0; p < 6; p++) begin
            int g;
            g = p % C_NUM_IN;
            @(negedge clk);
            check_idle("rr_arb");
            next_cycle();
            @(negedge clk);
            check_beat("rr_b0", g, 32'h100 * g, 1'b0);
            next_cycle();
            set_src(g, 1'b1, 32'h100 * g + 1, 1'b1);
            @(negedge clk);
            check_beat("rr_b1", g, 32'h100 * g + 1, 1'b1);
            next_cycle();
            set_src(g, 1'b1, 32'h100 * g, 1'b0);
        end
        s_tvalid = '0;
        s_tlast  = '0;
        next_cycle();

        // Backpressure and bubbles on source 1; source 0 waits
        set_src(1, 1'b1, 32'hC0, 1'b0);
        @(negedge clk);
        check_idle("bp_arb");
        next_cycle();
        set_src(0, 1'b1, 32'hD0, 1'b1);
        @(negedge clk);
        check_beat("bp_c1", 1, 32'hC0, 1'b0);
        check_val("bp_c1_sready", 32'(s_tready), 32'b0010);
        next_cycle();
        m_tready = 1'b0;
        set_src(1, 1'b1, 32'hC1, 1'b0);
        @(negedge clk);
        check_beat("bp_c2", 1, 32'hC1, 1'b0);
        check_val("bp_c2_sready", 32'(s_tready), 32'b0000);
        next_cycle();
        m_tready = 1'b1;
        @(negedge clk);
        check_beat("bp_c3", 1, 32'hC1, 1'b0);
        check_val("bp_c3_sready", 32'(s_tready), 32'b0010);
        next_cycle();
        m_tready = 1'b0;
        set_src(1, 1'b1, 32'hC2, 1'b0);
        @(negedge clk);
        check_val("bp_c4_sready", 32'(s_tready), 32'b0000);
        next_cycle();
        m_tready = 1'b1;
        set_src(1, 1'b0, 32'hC2, 1'b0);
        @(negedge clk);
        check_val("bp_bub_mvalid", 32'(m_tvalid), 32'd0);
        check_val("bp_bub_tid",    32'(m_tid),    32'd1);
        check_val("bp_bub_busy",   32'(busy),     32'd1);
        next_cycle();
        set_src(1, 1'b1, 32'hC2, 1'b0);
        @(negedge clk);
        check_beat("bp_c6", 1, 32'hC2, 1'b0);
        next_cycle();
        set_src(1, 1'b1, 32'hC3, 1'b1);
        @(negedge clk);
        check_beat("bp_c7", 1, 32'hC3, 1'b1);
        next_cycle();
        set_src(1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check_idle("bp_end");
        check_val("bp_pdone", 32'(pkt_done), 32'd1);
        next_cycle();
        @(negedge clk);
        check_beat("bp_s0", 0, 32'hD0, 1'b1);
        next_cycle();
        set_src(0, 1'b0, 32'h0, 1'b0);

        // arb_en gating: source 3 packet completes after arb_en drops
        set_src(3, 1'b1, 32'hE0, 1'b0);
        @(negedge clk);
        check_idle("en_arb");
        next_cycle();
        @(negedge clk);
        check_beat("en_b0", 3, 32'hE0, 1'b0);
        next_cycle();
        arb_en = 1'b0;
        set_src(3, 1'b1, 32'hE1, 1'b1);
        @(negedge clk);
        check_beat("en_b1", 3, 32'hE1, 1'b1);
        next_cycle();
        set_src(3, 1'b0, 32'h0, 1'b0);
        set_src(0, 1'b1, 32'hF0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle("en_hold");
            next_cycle();
        end
        arb_en = 1'b1;
        @(negedge clk);
        check_idle("en_rearb");
        next_cycle();
        @(negedge clk);
        check_beat("en_s0", 0, 32'hF0, 1'b1);
        next_cycle();
        set_src(0, 1'b0, 32'h0, 1'b0);

        // Reset mid-packet from source 1
        set_src(1, 1'b1, 32'h60, 1'b0);
        next_cycle();
        @(negedge clk);
        check_beat("mr_b0", 1, 32'h60, 1'b0);
        next_cycle();
        set_src(1, 1'b1, 32'h61, 1'b0);
        next_cycle();
        set_src(1, 1'b1, 32'h62, 1'b0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        set_src(0, 1'b1, 32'h70, 1'b1);
        @(negedge clk);
        check_idle("mr_after");
        check_val("mr_pdone", 32'(pkt_done), 32'd0);
        next_cycle();
        @(negedge clk);
        check_beat("mr_s0", 0, 32'h70, 1'b1);
        next_cycle();
        s_tvalid = '0;
        @(negedge clk);
        check_val("mr_s0_pdone", 32'(pkt_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
